// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: sequences one ALU operation per request, applies 6502 decimal
// correction over two extra cycles, and owns the processor status register P.
module cpu_alu_seq #(
  parameter logic [7:0] P_RESET = 8'h34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       clr_v,
  input  logic       load_p,
  input  logic [7:0] p_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] P
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_EOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  typedef enum logic [1:0] {IDLE, BIN, DEC_LO, DEC_HI} state_t;

  state_t     state, next_state;
  logic [7:0] a_q, b_q, p_q;
  logic [2:0] op_q;
  logic       c_q, d_q;
  logic [3:0] lo_q;
  logic       lo_cy_q;

  logic       is_arith, decimal;
  logic [8:0] sum9, diff9;
  logic [7:0] bin_res;
  logic       bin_c, bin_v;
  logic [5:0] lo_add, lo_add_adj, hi_add, hi_add_adj;
  logic [4:0] lo_diff;
  logic [3:0] lo_dec, hi_dec;
  logic       lo_dec_cy, dec_c;

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign decimal  = is_arith && d_q;
  assign busy     = (state != IDLE);
  assign P        = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = BIN;
      BIN:     next_state = decimal ? DEC_LO : IDLE;
      DEC_LO:  next_state = DEC_HI;
      DEC_HI:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Binary result from the latched operands; stays valid through the decimal states.
  always_comb begin
    sum9    = {1'b0, b_q} + {1'b0, a_q} + {8'd0, c_q};
    diff9   = {1'b0, b_q} - {1'b0, a_q} - {8'd0, ~c_q};
    bin_res = b_q;
    bin_c   = c_q;
    bin_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        bin_res = sum9[7:0];
        bin_c   = sum9[8];
        bin_v   = (a_q[7] == b_q[7]) && (sum9[7] != b_q[7]);
      end
      OP_SUB: begin
        bin_res = diff9[7:0];
        bin_c   = ~diff9[8];
        bin_v   = (a_q[7] != b_q[7]) && (diff9[7] != b_q[7]);
      end
      OP_OR:   bin_res = b_q | a_q;
      OP_AND:  bin_res = b_q & a_q;
      OP_EOR:  bin_res = b_q ^ a_q;
      OP_PASS: bin_res = b_q;
      OP_INC:  bin_res = b_q + 8'd1;
      default: bin_res = b_q;
    endcase
  end

  // Nibble corrections; the high nibble of ADD uses the registered low-nibble carry.
  always_comb begin
    lo_add     = {2'b00, a_q[3:0]} + {2'b00, b_q[3:0]} + {5'd0, c_q};
    lo_add_adj = (lo_add > 6'd9) ? lo_add + 6'd6 : lo_add;
    hi_add     = {2'b00, a_q[7:4]} + {2'b00, b_q[7:4]} + {5'd0, lo_cy_q};
    hi_add_adj = (hi_add > 6'd9) ? hi_add + 6'd6 : hi_add;
    lo_diff    = {1'b0, b_q[3:0]} - {1'b0, a_q[3:0]} - {4'd0, ~c_q};
    lo_dec     = lo_add_adj[3:0];
    lo_dec_cy  = |lo_add_adj[5:4];
    hi_dec     = hi_add_adj[3:0];
    dec_c      = |hi_add_adj[5:4];
    if (op_q == OP_SUB) begin
      lo_dec    = lo_diff[4] ? bin_res[3:0] - 4'd6 : bin_res[3:0];
      lo_dec_cy = 1'b0;
      hi_dec    = bin_c ? bin_res[7:4] : bin_res[7:4] - 4'd6;
      dec_c     = bin_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      d_q     <= 1'b0;
      lo_q    <= '0;
      lo_cy_q <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      p_q     <= P_RESET;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
            c_q  <= p_q[P_C];
            d_q  <= p_q[P_D];
          end else if (load_p) begin
            p_q <= p_in | 8'h20;
          end else begin
            if (set_c && !clr_c)      p_q[P_C] <= 1'b1;
            else if (clr_c && !set_c) p_q[P_C] <= 1'b0;
            if (set_d && !clr_d)      p_q[P_D] <= 1'b1;
            else if (clr_d && !set_d) p_q[P_D] <= 1'b0;
            if (set_i && !clr_i)      p_q[P_I] <= 1'b1;
            else if (clr_i && !set_i) p_q[P_I] <= 1'b0;
            if (clr_v)                p_q[P_V] <= 1'b0;
          end
        end
        BIN: begin
          if (!decimal) begin
            result   <= bin_res;
            p_q[P_N] <= bin_res[7];
            p_q[P_Z] <= (bin_res == 8'd0);
            if (is_arith) begin
              p_q[P_V] <= bin_v;
              p_q[P_C] <= bin_c;
            end
            done <= 1'b1;
          end
        end
        DEC_LO: begin
          lo_q    <= lo_dec;
          lo_cy_q <= lo_dec_cy;
        end
        DEC_HI: begin
          // N, Z and V follow the binary result; only C and result are decimal.
          result   <= {hi_dec, lo_q};
          p_q[P_N] <= bin_res[7];
          p_q[P_Z] <= (bin_res == 8'd0);
          p_q[P_V] <= bin_v;
          p_q[P_C] <= dec_c;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
